vga_bram_scanout: RTL and testbench
===================================

Name: vga_bram_scanout

Overview:
Parametrised VGA scan-out engine, successor to the fixed 640x480 VGA block. It generates hsync/vsync from fully configurable H/V timing, divides the system clock down to the pixel rate, and issues one BRAM read per displayed pixel. Added over the fixed block: pixel replication (scaling), a frame-latched base address for double buffering, a run enable, and pixel coordinate and frame_start status outputs. It sits between the frame-buffer BRAM and the VGA connector logic.

Parameters:
CLK_DIV_VAL, 4, clk cycles per pixel; legal values are 3 or more
H_ACTIVE, 640 / H_FP, 16 / H_SYNC, 96 / H_BP, 48, horizontal timing in pixels
V_ACTIVE, 480 / V_FP, 10 / V_SYNC, 2 / V_BP, 33, vertical timing in lines
SYNC_POL, 0, asserted sync level (0 = active-low)
SCALE_SHIFT, 0, pixel replication factor of 2^SCALE_SHIFT in both x and y
BYTES_PER_WORD, 4, address increment per BRAM word
ADDR_WIDTH, 32, bram_addr width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  run enable; low holds the block in its reset state
base_addr  in  ADDR_WIDTH  frame buffer base byte address
hsync  out  1  horizontal sync
vsync  out  1  vertical sync
bram_en  out  1  BRAM read enable
bram_addr  out  ADDR_WIDTH  BRAM byte address
active  out  1  visible-region flag
frame_start  out  1  one-clk pulse at pixel (0,0)
pix_x  out  12  current h_cnt
pix_y  out  12  current v_cnt

Behaviour:
- Totals: H_TOTAL = sum of the four H parameters; V_TOTAL = sum of the four V parameters.
- Region order on each axis: active, front porch, sync, back porch.
- div_cnt runs 0..CLK_DIV_VAL-1. A pixel tick occurs when div_cnt = CLK_DIV_VAL-1.
- On each tick, h_cnt increments. It wraps to 0 at H_TOTAL-1, and v_cnt increments on that wrap. v_cnt wraps to 0 at V_TOTAL-1.
- All outputs are registered. Each output reflects the counter state (div_cnt, h_cnt, v_cnt) of the previous clk.
- hsync = SYNC_POL when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, else ~SYNC_POL. vsync is defined the same way on v_cnt.
- active = (h_cnt < H_ACTIVE) and (v_cnt < V_ACTIVE).
- bram_en: exactly one clk per active pixel, decoded when div_cnt = 0. BRAM data (1-cycle latency) is therefore valid within the same pixel period.
- bram_addr = base_lat + ((v_cnt>>S)*(H_ACTIVE>>S) + (h_cnt>>S))*BYTES_PER_WORD, where S = SCALE_SHIFT, truncated to ADDR_WIDTH.
- bram_addr is updated only with bram_en and holds its last value otherwise.
- base_lat captures base_addr when the counter state is (0,0) with div_cnt = 0. A mid-frame change of base_addr takes effect only at the next frame.
- frame_start pulses for one clk, decoded at (0,0) with div_cnt = 0.
- Reset, or enable = 0:
  - counters = 0, base_lat = base_addr
  - hsync = vsync = ~SYNC_POL
  - bram_en = active = frame_start = 0
  - bram_addr = 0, pix_x = pix_y = 0
- Reset takes effect mid-line or mid-frame, on the next clk edge. No partial line completes.
- On reset/enable release, counting restarts at (0,0). frame_start occurs one clk after the first non-reset clk.
- reset has priority over enable.

Test Plan:
Common bench parameters: H = 8/2/3/1 (H_TOTAL = 14), V = 4/1/2/1 (V_TOTAL = 8), CLK_DIV_VAL = 4, SYNC_POL = 0, base_addr = 0.
1. Reset held for 5 clks → hsync = vsync = 1, bram_en = 0, bram_addr = 0, active = 0. After release, frame_start pulses once, and again every 448 clks.
2. Free run → hsync is low for 12 clks every 56 clks, starting when pix_x = 10. vsync is low for 112 clks (lines 5–6) every 448 clks.
3. Free run, one frame → exactly 32 bram_en pulses, each one clk wide and 4 clks apart within a line. Addresses run 0, 4, …, 124 in order.
4. SCALE_SHIFT = 1 → line 0 addresses are 0,0,4,4,8,8,12,12. Line 1 repeats line 0. Line 2 starts at 16.
5. base_addr changed to 0x1000 at line 2 → the rest of the current frame keeps base 0. The next frame's first bram_addr is 0x1000.
6. Mid-operation control:
   - reset asserted at pix_x = 5, pix_y = 1 → outputs take reset values on the next clk.
   - After release, counting restarts at (0,0).
   - enable = 0 for 20 clks → same reset behaviour.

Source files
------------

// File: rtl/vga_bram_scanout.sv
// vga_bram_scanout: parametrised VGA timing generator issuing one BRAM read per displayed pixel
module vga_bram_scanout #(
  parameter int CLK_DIV_VAL    = 4,
  parameter int H_ACTIVE       = 640,
  parameter int H_FP           = 16,
  parameter int H_SYNC         = 96,
  parameter int H_BP           = 48,
  parameter int V_ACTIVE       = 480,
  parameter int V_FP           = 10,
  parameter int V_SYNC         = 2,
  parameter int V_BP           = 33,
  parameter bit SYNC_POL       = 1'b0,
  parameter int SCALE_SHIFT    = 0,
  parameter int BYTES_PER_WORD = 4,
  parameter int ADDR_WIDTH     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  bram_en,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic                  active,
  output logic                  frame_start,
  output logic [11:0]           pix_x,
  output logic [11:0]           pix_y
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW = $clog2(CLK_DIV_VAL);
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV_VAL - 1);
  localparam logic [11:0] H_ACT = 12'(H_ACTIVE);
  localparam logic [11:0] H_SS  = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] H_SE  = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] H_MAX = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_ACT = 12'(V_ACTIVE);
  localparam logic [11:0] V_SS  = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] V_SE  = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] V_MAX = 12'(V_TOTAL - 1);
  localparam logic [ADDR_WIDTH-1:0] ROW_W = ADDR_WIDTH'(H_ACTIVE >> SCALE_SHIFT);
  localparam logic [ADDR_WIDTH-1:0] BPW = ADDR_WIDTH'(BYTES_PER_WORD);
  logic [DW-1:0] div_cnt;
  logic [11:0] h_cnt, v_cnt;
  logic [ADDR_WIDTH-1:0] base_lat, base_sel, pix_idx;
  logic tick, h_wrap, origin, vis, rd;
  // decode the current counter state; at the frame origin the live base is used so a new frame starts on the new buffer
  always_comb begin
    tick = div_cnt == DIV_MAX;
    h_wrap = h_cnt == H_MAX;
    origin = div_cnt == '0 && h_cnt == '0 && v_cnt == '0;
    vis = h_cnt < H_ACT && v_cnt < V_ACT;
    rd = vis && div_cnt == '0;
    base_sel = origin ? base_addr : base_lat;
    pix_idx = ADDR_WIDTH'(v_cnt >> SCALE_SHIFT) * ROW_W + ADDR_WIDTH'(h_cnt >> SCALE_SHIFT);
  end
  // clock divider, raster counters and once-per-frame base latch
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      div_cnt <= '0;
      h_cnt <= '0;
      v_cnt <= '0;
      base_lat <= base_addr;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) h_cnt <= h_wrap ? '0 : h_cnt + 1'b1;
      if (tick && h_wrap) v_cnt <= v_cnt == V_MAX ? '0 : v_cnt + 1'b1;
      if (origin) base_lat <= base_addr;
    end
  end
  // registered outputs, each reflecting the counter state of the previous clk
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      hsync <= ~SYNC_POL;
      vsync <= ~SYNC_POL;
      bram_en <= 1'b0;
      bram_addr <= '0;
      active <= 1'b0;
      frame_start <= 1'b0;
      pix_x <= '0;
      pix_y <= '0;
    end else begin
      hsync <= (h_cnt >= H_SS && h_cnt < H_SE) ? SYNC_POL : ~SYNC_POL;
      vsync <= (v_cnt >= V_SS && v_cnt < V_SE) ? SYNC_POL : ~SYNC_POL;
      bram_en <= rd;
      if (rd) bram_addr <= base_sel + pix_idx * BPW;
      active <= vis;
      frame_start <= origin;
      pix_x <= h_cnt;
      pix_y <= v_cnt;
    end
  end
endmodule

// File: tb/tb_vga_bram_scanout.sv
// tb_vga_bram_scanout: directed table-driven check of the scan-out engine on a tiny raster
module tb_vga_bram_scanout;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b1;
  logic [31:0] base_addr = 32'h0;
  logic hsync, vsync, bram_en, active, frame_start;
  logic [31:0] bram_addr;
  logic [11:0] pix_x, pix_y;
  logic s_hsync, s_vsync, s_en, s_active, s_fs;
  logic [31:0] s_addr;
  logic [11:0] s_x, s_y;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  vga_bram_scanout #(.CLK_DIV_VAL(4), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0), .SCALE_SHIFT(0),
    .BYTES_PER_WORD(4), .ADDR_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .enable(enable), .base_addr(base_addr),
    .hsync(hsync), .vsync(vsync), .bram_en(bram_en), .bram_addr(bram_addr),
    .active(active), .frame_start(frame_start), .pix_x(pix_x), .pix_y(pix_y));

  vga_bram_scanout #(.CLK_DIV_VAL(4), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0), .SCALE_SHIFT(1),
    .BYTES_PER_WORD(4), .ADDR_WIDTH(32)) dut_s (
    .clk(clk), .reset(reset), .enable(enable), .base_addr(base_addr),
    .hsync(s_hsync), .vsync(s_vsync), .bram_en(s_en), .bram_addr(s_addr),
    .active(s_active), .frame_start(s_fs), .pix_x(s_x), .pix_y(s_y));

  typedef struct {
    int k;
    bit hs, vs, en, act, fs;
    logic [31:0] addr;
    logic [11:0] x, y;
  } vec_t;
  localparam int NV = 16;
  vec_t tbl[NV];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input bit hs, input bit vs, input bit en, input bit act,
                         input bit fs, input logic [31:0] addr, input logic [11:0] x, input logic [11:0] y);
    chk({tag, ".hsync"}, hsync, hs);
    chk({tag, ".vsync"}, vsync, vs);
    chk({tag, ".bram_en"}, bram_en, en);
    chk({tag, ".active"}, active, act);
    chk({tag, ".frame_start"}, frame_start, fs);
    chk({tag, ".bram_addr"}, bram_addr, addr);
    chk({tag, ".pix_x"}, pix_x, x);
    chk({tag, ".pix_y"}, pix_y, y);
  endtask

  task automatic chk_rst(input string tag);
    chk_out(tag, 1, 1, 0, 0, 0, 32'h0, 12'd0, 12'd0);
    chk({tag, ".s_bram_en"}, s_en, 0);
    chk({tag, ".s_bram_addr"}, s_addr, 0);
  endtask

  initial begin
    int en_cnt[2];
    int s_cnt[2];
    int hs_low[2];
    int vs_low[2];
    int fs_cnt;
    int last_k;
    int last_y;
    bit prev_en;
    bit prev_hs;
    bit found;
    tbl[0]  = '{0,   1, 1, 1, 1, 1, 32'h0,    12'd0,  12'd0};
    tbl[1]  = '{1,   1, 1, 0, 1, 0, 32'h0,    12'd0,  12'd0};
    tbl[2]  = '{4,   1, 1, 1, 1, 0, 32'h4,    12'd1,  12'd0};
    tbl[3]  = '{29,  1, 1, 0, 1, 0, 32'd28,   12'd7,  12'd0};
    tbl[4]  = '{32,  1, 1, 0, 0, 0, 32'd28,   12'd8,  12'd0};
    tbl[5]  = '{40,  0, 1, 0, 0, 0, 32'd28,   12'd10, 12'd0};
    tbl[6]  = '{51,  0, 1, 0, 0, 0, 32'd28,   12'd12, 12'd0};
    tbl[7]  = '{52,  1, 1, 0, 0, 0, 32'd28,   12'd13, 12'd0};
    tbl[8]  = '{56,  1, 1, 1, 1, 0, 32'd32,   12'd0,  12'd1};
    tbl[9]  = '{224, 1, 1, 0, 0, 0, 32'd124,  12'd0,  12'd4};
    tbl[10] = '{280, 1, 0, 0, 0, 0, 32'd124,  12'd0,  12'd5};
    tbl[11] = '{391, 1, 0, 0, 0, 0, 32'd124,  12'd13, 12'd6};
    tbl[12] = '{392, 1, 1, 0, 0, 0, 32'd124,  12'd0,  12'd7};
    tbl[13] = '{447, 1, 1, 0, 0, 0, 32'd124,  12'd13, 12'd7};
    tbl[14] = '{448, 1, 1, 1, 1, 1, 32'h1000, 12'd0,  12'd0};
    tbl[15] = '{452, 1, 1, 1, 1, 0, 32'h1004, 12'd1,  12'd0};
    en_cnt = '{0, 0};
    s_cnt = '{0, 0};
    hs_low = '{0, 0};
    vs_low = '{0, 0};
    fs_cnt = 0;
    last_k = -100;
    last_y = -1;
    prev_en = 0;
    prev_hs = 1;
    repeat (5) @(posedge clk);
    #1 chk_rst("reset_hold");
    reset = 1'b0;
    for (int k = 0; k < 896; k++) begin
      int fr;
      logic [31:0] base;
      @(posedge clk);
      #1;
      fr = k / 448;
      base = fr == 0 ? 32'h0 : 32'h1000;
      for (int i = 0; i < NV; i++)
        if (tbl[i].k == k)
          chk_out($sformatf("vec_k%0d", k), tbl[i].hs, tbl[i].vs, tbl[i].en, tbl[i].act,
                  tbl[i].fs, tbl[i].addr, tbl[i].x, tbl[i].y);
      if (k == 120) base_addr = 32'h1000;
      if (bram_en) begin
        chk("en_width", prev_en, 0);
        chk("en_addr", bram_addr, base + 32'(en_cnt[fr] * 4));
        if (int'(pix_y) == last_y) chk("en_spacing", 32'(k - last_k), 32'd4);
        last_k = k;
        last_y = int'(pix_y);
        en_cnt[fr]++;
      end
      if (s_en) begin
        int m;
        m = s_cnt[fr];
        chk("scaled_addr", s_addr, base + 32'((((m / 8) >> 1) * 4 + ((m % 8) >> 1)) * 4));
        s_cnt[fr]++;
      end
      if (!hsync && prev_hs) chk("hsync_fall_x", pix_x, 12'd10);
      if (!hsync) hs_low[fr]++;
      if (!vsync) vs_low[fr]++;
      if (frame_start) fs_cnt++;
      prev_en = bram_en;
      prev_hs = hsync;
    end
    for (int f = 0; f < 2; f++) begin
      chk($sformatf("en_count_f%0d", f), en_cnt[f], 32);
      chk($sformatf("scaled_en_count_f%0d", f), s_cnt[f], 32);
      chk($sformatf("hsync_low_f%0d", f), hs_low[f], 96);
      chk($sformatf("vsync_low_f%0d", f), vs_low[f], 112);
    end
    chk("frame_start_count", fs_cnt, 2);
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(posedge clk);
      #1;
      found = pix_x == 12'd5 && pix_y == 12'd1;
    end
    chk("reach_x5_y1", found, 1);
    reset = 1'b1;
    @(posedge clk);
    #1 chk_rst("mid_reset");
    reset = 1'b0;
    @(posedge clk);
    #1 chk_out("rst_restart", 1, 1, 1, 1, 1, 32'h1000, 12'd0, 12'd0);
    repeat (4) @(posedge clk);
    #1 chk_out("rst_restart4", 1, 1, 1, 1, 0, 32'h1004, 12'd1, 12'd0);
    repeat (100) @(posedge clk);
    #1;
    enable = 1'b0;
    base_addr = 32'h2000;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1 chk_rst($sformatf("en_low%0d", i));
    end
    enable = 1'b1;
    @(posedge clk);
    #1 chk_out("en_restart", 1, 1, 1, 1, 1, 32'h2000, 12'd0, 12'd0);
    chk("en_restart_scaled", s_addr, 32'h2000);
    repeat (4) @(posedge clk);
    #1 chk_out("en_restart4", 1, 1, 1, 1, 0, 32'h2004, 12'd1, 12'd0);
    chk("en_restart4_scaled", s_addr, 32'h2000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
